// File: rtl/npc_unit.sv
// npc_unit: fetch PC register and next-PC selection with one delay slot and back-pressure buffering
`ifndef CmpOut_LEN
`define CmpOut_LEN 2
`define CmpOut_Less 2'd0
`define CmpOut_Eq 2'd1
`define CmpOut_Greater 2'd2
`endif

module npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   imem_ready,
    input  logic [2:0]             br_type,
    input  logic [31:0]            d_pc,
    input  logic [15:0]            imm16,
    input  logic [25:0]            instr_index,
    input  logic [31:0]            jr_target,
    input  logic [`CmpOut_LEN-1:0] cmp_out,
    input  logic                   cmp_gez,
    output logic [31:0]            f_pc,
    output logic [31:0]            link_addr,
    output logic                   redirect,
    output logic                   pending
);
    typedef enum logic {IDLE, PENDING} state_t;
    state_t      state, state_next;
    logic [31:0] buf_tgt, buf_next, pc_next, pc4, target;
    logic        taken, advance, capture;

    assign link_addr = d_pc + 32'd8;
    assign pending   = state == PENDING;
    assign redirect  = state == IDLE && taken;
    assign advance   = !stall && imem_ready;
    assign capture   = state == IDLE && !stall && !imem_ready && redirect;

    // resolve whether the transfer in D is taken and where it goes
    always_comb begin
        pc4    = d_pc + 32'd4;
        taken  = br_type == 3'd1 ? cmp_out == `CmpOut_Eq :
                 br_type == 3'd2 ? cmp_out != `CmpOut_Eq :
                 br_type == 3'd3 ? cmp_gez :
                 br_type == 3'd4 ? !cmp_gez :
                 br_type == 3'd5 || br_type == 3'd6;
        target = br_type == 3'd5 ? {pc4[31:28], instr_index, 2'b00} :
                 br_type == 3'd6 ? jr_target :
                 pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    end

    // state register, PC and redirect buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            f_pc    <= RESET_PC;
            buf_tgt <= 32'd0;
        end else begin
            state   <= state_next;
            f_pc    <= pc_next;
            buf_tgt <= buf_next;
        end
    end

    // park a redirect that arrives while imem refuses the delay slot, release it on acceptance
    always_comb begin
        state_next = state;
        if (capture) state_next = PENDING;
        if (state == PENDING && advance) state_next = IDLE;
    end

    // next fetch address and buffer contents
    always_comb begin
        pc_next  = !advance ? f_pc :
                   state == PENDING ? buf_tgt :
                   redirect ? target : f_pc + PC_STEP;
        buf_next = capture ? target : buf_tgt;
    end
endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: directed self-checking bench for npc_unit
`ifndef CmpOut_LEN
`define CmpOut_LEN 2
`define CmpOut_Less 2'd0
`define CmpOut_Eq 2'd1
`define CmpOut_Greater 2'd2
`endif

module tb_npc_unit;
    logic                   clk = 0;
    logic                   rst_n, stall, imem_ready, cmp_gez;
    logic [2:0]             br_type;
    logic [31:0]            d_pc, jr_target, f_pc, link_addr;
    logic [15:0]            imm16;
    logic [25:0]            instr_index;
    logic [`CmpOut_LEN-1:0] cmp_out;
    logic                   redirect, pending;
    int                     compared = 0, mismatched = 0;

    npc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .imem_ready(imem_ready),
        .br_type(br_type), .d_pc(d_pc), .imm16(imm16), .instr_index(instr_index),
        .jr_target(jr_target), .cmp_out(cmp_out), .cmp_gez(cmp_gez),
        .f_pc(f_pc), .link_addr(link_addr), .redirect(redirect), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; imem_ready = 1; br_type = 0; d_pc = 0; imm16 = 0;
        instr_index = 0; jr_target = 0; cmp_out = `CmpOut_Less; cmp_gez = 0;
        #12;
        check("reset_pc", f_pc, 32'h3000);
        check("reset_pending", {31'd0, pending}, 0);
        rst_n = 1;
        tick(); check("seq1", f_pc, 32'h3004);
        tick(); check("seq2", f_pc, 32'h3008);
        tick(); check("seq3", f_pc, 32'h300C);

        br_type = 1; d_pc = 32'h3004; imm16 = 16'hFFFF; cmp_out = `CmpOut_Eq; #1;
        check("beq_redirect", {31'd0, redirect}, 1);
        check("beq_link", link_addr, 32'h300C);
        tick(); check("beq_taken_pc", f_pc, 32'h3004);
        cmp_out = `CmpOut_Less; #1;
        check("beq_nt_redirect", {31'd0, redirect}, 0);
        tick(); check("beq_nt_pc", f_pc, 32'h3008);

        br_type = 2; cmp_out = 2'd3; #1;
        check("bne_other_code", {31'd0, redirect}, 1);
        br_type = 7; #1;
        check("reserved_nt", {31'd0, redirect}, 0);

        br_type = 4; d_pc = 32'h3010; imm16 = 16'h0004; cmp_gez = 1; #1;
        check("bltz_nt", {31'd0, redirect}, 0);
        br_type = 3; #1;
        check("bgez_redirect", {31'd0, redirect}, 1);
        tick(); check("bgez_pc", f_pc, 32'h3024);
        br_type = 5; instr_index = 26'h0000C40; #1;
        check("jal_link", link_addr, 32'h3018);
        tick(); check("jal_pc", f_pc, 32'h3100);

        br_type = 6; jr_target = 32'h4000; imem_ready = 0; #1;
        check("jr_redirect", {31'd0, redirect}, 1);
        tick();
        check("bp1_pc", f_pc, 32'h3100);
        check("bp1_pending", {31'd0, pending}, 1);
        br_type = 1; cmp_out = `CmpOut_Eq; #1;
        check("pend_redirect_forced", {31'd0, redirect}, 0);
        tick();
        check("bp2_pc", f_pc, 32'h3100);
        check("bp2_pending", {31'd0, pending}, 1);
        imem_ready = 1;
        tick();
        check("pend_release_pc", f_pc, 32'h4000);
        check("pend_release_pending", {31'd0, pending}, 0);

        d_pc = 32'h4000; imm16 = 16'h0010; stall = 1; #1;
        check("stall_redirect", {31'd0, redirect}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", f_pc, 32'h4000);
            check("stall_pending", {31'd0, pending}, 0);
        end
        stall = 0;
        tick(); check("stall_release_pc", f_pc, 32'h4044);

        br_type = 6; jr_target = 32'hFFFF_FFFC;
        tick(); check("jr_top_pc", f_pc, 32'hFFFF_FFFC);
        br_type = 0;
        tick(); check("wrap_pc", f_pc, 32'h0000_0000);
        br_type = 6; jr_target = 32'h5000; imem_ready = 0;
        tick(); check("rst_pre_pending", {31'd0, pending}, 1);
        #2 rst_n = 0; #1;
        check("async_rst_pc", f_pc, 32'h3000);
        check("async_rst_pending", {31'd0, pending}, 0);
        rst_n = 1; br_type = 0; imem_ready = 1;
        tick(); check("post_rst_pc", f_pc, 32'h3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
